// File: rtl/core_mem_port.sv
// core_mem_port: per-core memory access stage in front of the shared-RAM arbiter.
// Core requests are queued in a small FIFO. They are then presented one at a time
// on this core's arbiter lane, and each one completes with a single-cycle done pulse.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req/we/addr/wdata core request; accepted when req && !full
//   full, busy        FIFO full; FIFO non-empty or an op in flight
//   rdata, done, err  load result, completion pulse, timeout flag (with done)
//   mem_rden/mem_wren read/write request to the arbiter lane
//   mem_address/din   address and write data, held from REQ through DONE
//   mem_acq, mem_dq   grant and read data returned by the arbiter
module core_mem_port #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 2,
    parameter int RD_WAIT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_din,
    input  logic              mem_acq,
    input  logic [DATA_W-1:0] mem_dq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(TIMEOUT + RD_WAIT + 1);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] TICK     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RW_LAST  = CNT_W'(RD_WAIT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [ENT_W-1:0]  fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_cur_q, we_cur_d;
    logic [ADDR_W-1:0] addr_cur_q, addr_cur_d;
    logic [DATA_W-1:0] din_cur_q, din_cur_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    assign fifo_empty = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign push       = req && !full;
    // A grant still high from the previous op must fall before the next op starts.
    assign pop        = (state_q == S_IDLE) && !fifo_empty && !mem_acq;
    assign head       = fifo_mem_q[rd_ptr_q];

    // Queue storage carries no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {we, addr, wdata};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_cur_d   = we_cur_q;
        addr_cur_d = addr_cur_q;
        din_cur_d  = din_cur_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    we_cur_d   = head[ENT_W-1];
                    addr_cur_d = head[ENT_W-2 -: ADDR_W];
                    din_cur_d  = head[DATA_W-1:0];
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_acq) begin
                    // The same counter times the read latency after a grant.
                    cnt_d   = '0;
                    state_d = we_cur_q ? S_DONE : S_WAIT;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + TICK;
                end
            end
            S_WAIT: begin
                if (cnt_q == RW_LAST) begin
                    rdata_d = mem_dq;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + TICK;
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // A timed-out op never got a grant, so there is nothing to wait for.
                if (err_q || !mem_acq) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_cur_q   <= 1'b0;
            addr_cur_q <= '0;
            din_cur_q  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_cur_q   <= we_cur_d;
            addr_cur_q <= addr_cur_d;
            din_cur_q  <= din_cur_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign busy        = !fifo_empty || (state_q != S_IDLE);
    assign mem_rden    = ((state_q == S_REQ) && !we_cur_q) || (state_q == S_WAIT);
    assign mem_wren    = (state_q == S_REQ) && we_cur_q;
    assign mem_address = addr_cur_q;
    assign mem_din     = din_cur_q;
    assign rdata       = rdata_q;
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_DONE) && err_q;

endmodule
